// File: rtl/sdram_req_arbiter.sv
// rtl/sdram_req_arbiter.sv - round-robin merge of WB and DMA clients into one SDRAM request stream
// Single outstanding request; read data is steered back to the source recorded at grant.
module sdram_req_arbiter #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32,
  parameter int N_DMA  = 3
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_dat_i,
  input  logic [31:0]               wbs_adr_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  input  logic [N_DMA-1:0]          dma_in_valid,
  input  logic [N_DMA-1:0]          dma_rw,
  input  logic [N_DMA*ADDR_W-1:0]   dma_address,
  input  logic [N_DMA*DATA_W-1:0]   dma_wdata,
  output logic [N_DMA-1:0]          dma_busy,
  output logic [N_DMA-1:0]          dma_out_valid,
  output logic [DATA_W-1:0]         dma_rdata,
  output logic                      ctrl_in_valid,
  output logic                      ctrl_rw,
  output logic [ADDR_W-1:0]         ctrl_address,
  output logic [DATA_W-1:0]         ctrl_wdata,
  input  logic                      ctrl_busy,
  input  logic                      ctrl_out_valid,
  input  logic [DATA_W-1:0]         ctrl_rdata
);

  localparam int N_SRC = N_DMA + 1;
  localparam int SRC_W = $clog2(N_SRC);
  localparam logic [SRC_W-1:0] WB_SRC = SRC_W'(N_DMA);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RD} state_t;

  state_t              state_q;
  logic [SRC_W-1:0]    last_grant_q;
  logic [SRC_W-1:0]    src_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ctrl_in_valid_q;
  logic                wbs_ack_q;
  logic [31:0]         wbs_dat_q;
  logic [N_DMA-1:0]    dma_out_valid_q;
  logic [DATA_W-1:0]   dma_rdata_q;

  logic                wb_req;
  logic [N_SRC-1:0]    req_vec;
  logic                gnt_valid;
  logic [SRC_W-1:0]    gnt_idx;
  logic                grant_ok;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_rw;
  logic [DATA_W-1:0]   sel_wdata;

  logic unused_inputs;
  assign unused_inputs = ^{wbs_sel_i, wbs_adr_i[31:ADDR_W]};

  function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % N_SRC;
    return SRC_W'(s);
  endfunction

  // Masking with the ack keeps a still-strobing WB master from being taken twice.
  assign wb_req  = wbs_stb_i & wbs_cyc_i & ~wbs_ack_q;
  assign req_vec = {wb_req, dma_in_valid};

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!gnt_valid && req_vec[rr_idx(last_grant_q, k)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = rr_idx(last_grant_q, k);
      end
    end
  end

  assign grant_ok = gnt_valid && (state_q == ST_IDLE) && !wb_rst_i;

  always_comb begin
    dma_busy = '1;
    for (int i = 0; i < N_DMA; i++) begin
      if (grant_ok && gnt_idx == SRC_W'(i)) dma_busy[i] = 1'b0;
    end
  end

  always_comb begin
    sel_addr  = wbs_adr_i[ADDR_W-1:0];
    sel_rw    = wbs_we_i;
    sel_wdata = wbs_dat_i;
    for (int i = 0; i < N_DMA; i++) begin
      if (gnt_idx == SRC_W'(i)) begin
        sel_addr  = dma_address[i*ADDR_W +: ADDR_W];
        sel_rw    = dma_rw[i];
        sel_wdata = dma_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= WB_SRC;
      src_q           <= '0;
      rw_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      ctrl_in_valid_q <= 1'b0;
      wbs_ack_q       <= 1'b0;
      wbs_dat_q       <= '0;
      dma_out_valid_q <= '0;
      dma_rdata_q     <= '0;
    end else begin
      wbs_ack_q       <= 1'b0;
      dma_out_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant_ok) begin
            addr_q          <= sel_addr;
            rw_q            <= sel_rw;
            wdata_q         <= sel_wdata;
            src_q           <= gnt_idx;
            last_grant_q    <= gnt_idx;
            ctrl_in_valid_q <= 1'b1;
            state_q         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!ctrl_busy) begin
            ctrl_in_valid_q <= 1'b0;
            if (rw_q) begin
              state_q <= ST_IDLE;
              // Only WB gets a write completion; DMA writes finish at acceptance.
              if (src_q == WB_SRC) wbs_ack_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT_RD;
            end
          end
        end
        ST_WAIT_RD: begin
          if (ctrl_out_valid) begin
            state_q <= ST_IDLE;
            if (src_q == WB_SRC) begin
              wbs_dat_q <= ctrl_rdata;
              wbs_ack_q <= 1'b1;
            end else begin
              dma_rdata_q     <= ctrl_rdata;
              dma_out_valid_q <= N_DMA'(1) << src_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ctrl_in_valid = ctrl_in_valid_q;
  assign ctrl_rw       = rw_q;
  assign ctrl_address  = addr_q;
  assign ctrl_wdata    = wdata_q;
  assign wbs_ack_o     = wbs_ack_q;
  assign wbs_dat_o     = wbs_dat_q;
  assign dma_out_valid = dma_out_valid_q;
  assign dma_rdata     = dma_rdata_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb/tb_sdram_req_arbiter.sv - scoreboard bench for sdram_req_arbiter
// Stimulus queues expected requests/responses; a monitor pops and compares them.
module tb_sdram_req_arbiter;

  localparam int AW = 23;
  localparam int DW = 32;
  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              wb_rst_i;
  logic              wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_dat_i, wbs_adr_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [ND-1:0]     dma_in_valid, dma_rw;
  logic [ND*AW-1:0]  dma_address;
  logic [ND*DW-1:0]  dma_wdata;
  logic [ND-1:0]     dma_busy, dma_out_valid;
  logic [DW-1:0]     dma_rdata;
  logic              ctrl_in_valid, ctrl_rw;
  logic [AW-1:0]     ctrl_address;
  logic [DW-1:0]     ctrl_wdata;
  logic              ctrl_busy, ctrl_out_valid;
  logic [DW-1:0]     ctrl_rdata;

  sdram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_DMA(ND)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .dma_in_valid(dma_in_valid), .dma_rw(dma_rw), .dma_address(dma_address),
    .dma_wdata(dma_wdata), .dma_busy(dma_busy), .dma_out_valid(dma_out_valid),
    .dma_rdata(dma_rdata),
    .ctrl_in_valid(ctrl_in_valid), .ctrl_rw(ctrl_rw), .ctrl_address(ctrl_address),
    .ctrl_wdata(ctrl_wdata), .ctrl_busy(ctrl_busy), .ctrl_out_valid(ctrl_out_valid),
    .ctrl_rdata(ctrl_rdata)
  );

  typedef struct { logic rw; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;
  typedef struct { int src; logic [DW-1:0] data; logic is_rd; } rsp_t;
  typedef struct { logic [DW-1:0] data; int delay; } rd_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  rd_t  rd_q[$];

  int errors = 0;
  int checks = 0;
  int n_accept = 0;
  bit spur = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.rw = rw; r.addr = a; r.wdata = d;
    exp_req_q.push_back(r);
  endtask

  task automatic push_rsp(input int src, input logic [DW-1:0] d, input logic is_rd);
    rsp_t p;
    p.src = src; p.data = d; p.is_rd = is_rd;
    exp_rsp_q.push_back(p);
  endtask

  task automatic push_rd(input logic [DW-1:0] d, input int dly);
    rd_t x;
    x.data = d; x.delay = dly;
    rd_q.push_back(x);
  endtask

  // Monitor: ctrl-side requests and source-side responses against the scoreboard.
  initial begin
    req_t r;
    rsp_t p;
    logic [3:0] act_vec;
    logic prev_cov;
    prev_cov = 1'b0;
    forever begin
      @(negedge clk);
      if (ctrl_in_valid && !ctrl_busy) begin
        n_accept++;
        if (exp_req_q.size() == 0) check("ctrl_req_unexpected", ctrl_in_valid, 0);
        else begin
          r = exp_req_q.pop_front();
          check("ctrl_rw", ctrl_rw, r.rw);
          check("ctrl_address", ctrl_address, r.addr);
          if (r.rw) check("ctrl_wdata", ctrl_wdata, r.wdata);
        end
      end
      if (wbs_ack_o || (dma_out_valid != '0)) begin
        act_vec = {wbs_ack_o, dma_out_valid};
        if (exp_rsp_q.size() == 0) check("rsp_unexpected", act_vec, 0);
        else begin
          p = exp_rsp_q.pop_front();
          check("rsp_owner", act_vec, 4'(1) << p.src);
          if (p.is_rd) begin
            check("rsp_data", wbs_ack_o ? wbs_dat_o : dma_rdata, p.data);
            check("rsp_latency", prev_cov, 1);
          end
        end
      end
      prev_cov = ctrl_out_valid;
    end
  end

  // SDRAM controller model: answers each accepted read after its queued delay.
  initial begin
    bit take_rd;
    int cnt;
    logic [DW-1:0] pend;
    rd_t it;
    cnt = 0;
    pend = '0;
    ctrl_out_valid = 1'b0;
    ctrl_rdata = '0;
    forever begin
      @(negedge clk);
      take_rd = ctrl_in_valid && !ctrl_busy && !ctrl_rw;
      @(posedge clk);
      #1;
      ctrl_out_valid = 1'b0;
      if (take_rd && rd_q.size() > 0) begin
        it = rd_q.pop_front();
        pend = it.data;
        cnt = it.delay;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ctrl_out_valid = 1'b1;
          ctrl_rdata = pend;
        end
      end
      if (spur) begin
        ctrl_out_valid = 1'b1;
        ctrl_rdata = 32'hBAD0_BAD0;
        spur = 1'b0;
      end
    end
  end

  task automatic dma_req(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    dma_in_valid[i] = 1'b1;
    dma_rw[i] = rw;
    dma_address[i*AW +: AW] = a;
    dma_wdata[i*DW +: DW] = d;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (!dma_busy[i]) ok = 1'b1;
    end
    if (!ok) check("dma_grant_timeout", dma_busy[i], 0);
    tick();
    dma_in_valid[i] = 1'b0;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_adr_i = a; wbs_dat_i = d;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (wbs_ack_o) ok = 1'b1;
    end
    if (!ok) check("wb_ack_timeout", wbs_ack_o, 1);
    tick();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 300; t++) begin
      if (exp_rsp_q.size() == 0 && exp_req_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, exp_rsp_q.size() + exp_req_q.size(), 0);
    tick();
  endtask

  task automatic check_quiet(input string name, input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      check(name, {wbs_ack_o, dma_out_valid}, 0);
    end
  endtask

  initial begin
    int base;
    wb_rst_i = 1'b1;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 4'hF;
    wbs_dat_i = '0; wbs_adr_i = '0;
    dma_in_valid = '0; dma_rw = '0; dma_address = '0; dma_wdata = '0;
    ctrl_busy = 1'b0;

    // Reset state, with a DMA request present that must stay refused.
    tick();
    dma_in_valid = 3'b001;
    tick();
    @(negedge clk);
    check("rst_dma_busy", dma_busy, 3'b111);
    check("rst_ctrl_in_valid", ctrl_in_valid, 0);
    check("rst_wb_ack", wbs_ack_o, 0);
    check("rst_dma_out_valid", dma_out_valid, 0);
    tick();
    dma_in_valid = '0;
    wb_rst_i = 1'b0;
    tick();

    // Single WB write with cycle-exact latency.
    push_req(1'b1, 23'h10, 32'hDEAD_BEEF);
    push_rsp(ND, '0, 1'b0);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h10; wbs_dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t1_valid_at_accept", ctrl_in_valid, 0);
    check("t1_dma_busy_wb_grant", dma_busy, 3'b111);
    @(negedge clk);
    check("t1_valid_n1", ctrl_in_valid, 1);
    check("t1_ack_n1", wbs_ack_o, 0);
    @(negedge clk);
    check("t1_ack_n2", wbs_ack_o, 1);
    tick();
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    @(negedge clk);
    check("t1_ack_single", wbs_ack_o, 0);
    tick();

    // WB read, controller answers three cycles after taking it.
    push_rd(32'h1234_5678, 3);
    push_req(1'b0, 23'h20, '0);
    push_rsp(ND, 32'h1234_5678, 1'b1);
    wb_xfer(1'b0, 32'h20, '0);
    repeat (5) @(negedge clk);
    check("t2_no_second_req", ctrl_in_valid, 0);
    tick();

    // Round robin from reset: FIR, MM, QS, WB, FIR.
    wb_rst_i = 1'b1;
    tick();
    tick();
    wb_rst_i = 1'b0;
    push_req(1'b0, 23'h100, '0); push_rsp(0, 32'hA100_0001, 1'b1); push_rd(32'hA100_0001, 3);
    push_req(1'b0, 23'h200, '0); push_rsp(1, 32'hA200_0002, 1'b1); push_rd(32'hA200_0002, 3);
    push_req(1'b0, 23'h300, '0); push_rsp(2, 32'hA300_0003, 1'b1); push_rd(32'hA300_0003, 3);
    push_req(1'b0, 23'h400, '0); push_rsp(3, 32'hA400_0004, 1'b1); push_rd(32'hA400_0004, 3);
    push_req(1'b0, 23'h100, '0); push_rsp(0, 32'hA500_0005, 1'b1); push_rd(32'hA500_0005, 3);
    base = n_accept;
    dma_rw = '0;
    dma_address = {23'h300, 23'h200, 23'h100};
    dma_in_valid = 3'b111;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h400;
    for (int t = 0; t < 200; t++) begin
      if (n_accept - base >= 5) break;
      @(negedge clk);
    end
    tick();
    dma_in_valid = '0;
    wbs_cyc_i = 0; wbs_stb_i = 0;
    check("t3_accept_count", n_accept - base, 5);
    wait_drain("t3_drain");

    // Controller stalls five cycles during ISSUE.
    ctrl_busy = 1'b1;
    push_req(1'b1, 23'h300, 32'hCAFE_0003);
    dma_req(2, 1'b1, 23'h300, 32'hCAFE_0003);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_hold_valid", ctrl_in_valid, 1);
      check("t4_hold_address", ctrl_address, 23'h300);
      check("t4_hold_rw", ctrl_rw, 1);
      check("t4_hold_wdata", ctrl_wdata, 32'hCAFE_0003);
    end
    tick();
    ctrl_busy = 1'b0;
    @(negedge clk);
    check("t4_valid_at_release", ctrl_in_valid, 1);
    @(negedge clk);
    check("t4_taken_first_free", ctrl_in_valid, 0);
    tick();

    // Spurious controller read data while idle, then a real MM read.
    spur = 1'b1;
    check_quiet("t5_spurious_ignored", 4);
    tick();
    push_rd(32'h55AA_0001, 1);
    push_req(1'b0, 23'h200, '0);
    push_rsp(1, 32'h55AA_0001, 1'b1);
    dma_req(1, 1'b0, 23'h200, '0);
    wait_drain("t5_drain");

    // Reset while MM waits for read data; late data must be dropped.
    push_rd(32'hDEAD_0BAD, 6);
    push_req(1'b0, 23'h104, '0);
    dma_req(1, 1'b0, 23'h104, '0);
    tick();
    tick();
    wb_rst_i = 1'b1;
    tick();
    @(negedge clk);
    check("t6_rst_dma_busy", dma_busy, 3'b111);
    check("t6_rst_ctrl_in_valid", ctrl_in_valid, 0);
    tick();
    wb_rst_i = 1'b0;
    @(negedge clk);
    check("t6_post_dma_busy", dma_busy, 3'b111);
    check("t6_post_ctrl_in_valid", ctrl_in_valid, 0);
    check_quiet("t6_late_data_ignored", 6);
    tick();
    push_rd(32'hF00D_0001, 2);
    push_rd(32'hF00D_0002, 2);
    push_req(1'b0, 23'h004, '0); push_rsp(0, 32'hF00D_0001, 1'b1);
    push_req(1'b0, 23'h108, '0); push_rsp(1, 32'hF00D_0002, 1'b1);
    fork
      dma_req(0, 1'b0, 23'h004, '0);
      dma_req(1, 1'b0, 23'h108, '0);
    join
    wait_drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
